// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the program-counter sequencer: instruction field
//   widths, opcode values, PC step-select encodings, FSM state encoding and
//   the instruction class produced by the decoder.
package pc_sequencer_pkg;

  localparam int IW  = 16;  // instruction width
  localparam int OPW = 4;   // opcode width
  localparam int RAW = 4;   // register address / offset width

  // Opcodes (op = instr[15:12])
  localparam logic [OPW-1:0] OP_NOP    = 4'h0;
  localparam logic [OPW-1:0] OP_ALU_LO = 4'h1;
  localparam logic [OPW-1:0] OP_ALU_HI = 4'h7;
  localparam logic [OPW-1:0] OP_BRZ    = 4'h8;
  localparam logic [OPW-1:0] OP_BRN    = 4'h9;
  localparam logic [OPW-1:0] OP_JMP    = 4'hA;
  localparam logic [OPW-1:0] OP_BRA    = 4'hB;
  localparam logic [OPW-1:0] OP_HALT   = 4'hF;

  // PC step select towards program_counter
  localparam logic [1:0] PS_HOLD = 2'b00;  // PC unchanged
  localparam logic [1:0] PS_INC  = 2'b01;  // PC + 1
  localparam logic [1:0] PS_BR   = 2'b10;  // PC + offset + 1
  localparam logic [1:0] PS_JMP  = 2'b11;  // PC + R[sa]

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  // What the EXECUTE cycle has to do with an instruction
  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_BRZ  = 3'd2,
    CLS_BRN  = 3'd3,
    CLS_JMP  = 3'd4,
    CLS_BRA  = 3'd5,
    CLS_HALT = 3'd6
  } instr_class_t;

  // Opcode -> class; unassigned opcodes (C, D, E) behave as NOP.
  function automatic instr_class_t classify(input logic [OPW-1:0] op);
    instr_class_t cls;
    cls = CLS_NOP;
    if (op >= OP_ALU_LO && op <= OP_ALU_HI) begin
      cls = CLS_ALU;
    end else begin
      case (op)
        OP_BRZ:  cls = CLS_BRZ;
        OP_BRN:  cls = CLS_BRN;
        OP_JMP:  cls = CLS_JMP;
        OP_BRA:  cls = CLS_BRA;
        OP_HALT: cls = CLS_HALT;
        default: cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/pc_sequencer_decoder.sv
// pc_instr_decoder
//   Combinational split of the instruction register into its fields and
//   instruction class.
//   ir      in   IW   instruction register
//   op      out  OPW  opcode, ir[15:12]
//   dr      out  RAW  destination register, ir[11:8]
//   sa      out  RAW  source A, ir[7:4]
//   sb      out  RAW  source B, ir[3:0]
//   offset  out  RAW  branch offset, ir[3:0] (shares bits with sb)
//   cls     out  3    instruction class
module pc_instr_decoder
  import pc_sequencer_pkg::*;
(
  input  logic [IW-1:0]  ir,
  output logic [OPW-1:0] op,
  output logic [RAW-1:0] dr,
  output logic [RAW-1:0] sa,
  output logic [RAW-1:0] sb,
  output logic [RAW-1:0] offset,
  output instr_class_t   cls
);

  assign op     = ir[15:12];
  assign dr     = ir[11:8];
  assign sa     = ir[7:4];
  assign sb     = ir[3:0];
  assign offset = ir[3:0];
  assign cls    = classify(ir[15:12]);

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch/decode/execute sequencer driving program_counter. One PC update
//   (PS != 00) is issued per executed instruction, in its EXECUTE cycle.
//   clk_main   in   1    clock, all state on posedge
//   reset      in   1    synchronous, active-high
//   run        in   1    level; start/continue fetching
//   fetch_req  out  1    request instruction at current PC
//   fetch_ack  in   1    instruction valid, completes fetch
//   instr      in   IW   instruction word
//   zero_flag  in   1    ALU result == 0
//   neg_flag   in   1    ALU result MSB
//   PS         out  2    PC step select
//   offset     out  RAW  branch offset
//   sa/sb/dr   out  RAW  regfile read A / read B / write address
//   fs         out  OPW  ALU function select
//   rw         out  1    regfile write enable
//   halted     out  1    sequencer halted
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for run
// FETCH    | fetch_req high, waiting (unbounded) for fetch_ack
// DECODE   | IR fields registered onto sa/sb/dr/offset/fs
// EXECUTE  | one cycle: PS != 00 (except HALT), rw for ALU ops
// HALT     | sticky until reset, run ignored
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic           clk_main,
  input  logic           reset,
  input  logic           run,
  output logic           fetch_req,
  input  logic           fetch_ack,
  input  logic [IW-1:0]  instr,
  input  logic           zero_flag,
  input  logic           neg_flag,
  output logic [1:0]     PS,
  output logic [RAW-1:0] offset,
  output logic [RAW-1:0] sa,
  output logic [RAW-1:0] sb,
  output logic [RAW-1:0] dr,
  output logic [OPW-1:0] fs,
  output logic           rw,
  output logic           halted
);

  state_t       state;
  instr_class_t cls_q;
  logic [IW-1:0] ir;

  logic [OPW-1:0] dec_op;
  logic [RAW-1:0] dec_dr;
  logic [RAW-1:0] dec_sa;
  logic [RAW-1:0] dec_sb;
  logic [RAW-1:0] dec_offset;
  instr_class_t   dec_cls;

  pc_instr_decoder u_decoder (
    .ir     (ir),
    .op     (dec_op),
    .dr     (dec_dr),
    .sa     (dec_sa),
    .sb     (dec_sb),
    .offset (dec_offset),
    .cls    (dec_cls)
  );

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state     <= ST_IDLE;
      ir        <= '0;
      cls_q     <= CLS_NOP;
      fetch_req <= 1'b0;
      rw        <= 1'b0;
      halted    <= 1'b0;
      sa        <= '0;
      sb        <= '0;
      dr        <= '0;
      fs        <= '0;
      offset    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state     <= ST_FETCH;
            fetch_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (fetch_ack) begin
            ir        <= instr;
            fetch_req <= 1'b0;
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          sa     <= dec_sa;
          sb     <= dec_sb;
          dr     <= dec_dr;
          offset <= dec_offset;
          fs     <= dec_op;
          cls_q  <= dec_cls;
          rw     <= (dec_cls == CLS_ALU);
          state  <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          rw <= 1'b0;
          if (cls_q == CLS_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else if (run) begin
            state     <= ST_FETCH;
            fetch_req <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          fetch_req <= 1'b0;
          rw        <= 1'b0;
        end
      endcase
    end
  end

  // PS is decoded from registered state and class only; the flags are the
  // one live input, since the ALU only sees sa/sb once EXECUTE has begun and
  // a branch has to act on the flags of that same cycle.
  logic [1:0] ps_next;

  always_comb begin
    ps_next = PS_HOLD;
    if (state == ST_EXECUTE) begin
      case (cls_q)
        CLS_NOP:  ps_next = PS_INC;
        CLS_ALU:  ps_next = PS_INC;
        CLS_BRZ:  ps_next = zero_flag ? PS_BR : PS_INC;
        CLS_BRN:  ps_next = neg_flag ? PS_BR : PS_INC;
        CLS_JMP:  ps_next = PS_JMP;
        CLS_BRA:  ps_next = PS_BR;
        CLS_HALT: ps_next = PS_HOLD;
        default:  ps_next = PS_INC;
      endcase
    end
  end

  assign PS = ps_next;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk_main = 1'b0;
  logic        reset;
  logic        run;
  logic        fetch_req;
  logic        fetch_ack;
  logic [15:0] instr;
  logic        zero_flag;
  logic        neg_flag;
  logic [1:0]  PS;
  logic [3:0]  offset;
  logic [3:0]  sa;
  logic [3:0]  sb;
  logic [3:0]  dr;
  logic [3:0]  fs;
  logic        rw;
  logic        halted;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .run       (run),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .instr     (instr),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag),
    .PS        (PS),
    .offset    (offset),
    .sa        (sa),
    .sb        (sb),
    .dr        (dr),
    .fs        (fs),
    .rw        (rw),
    .halted    (halted)
  );

  always #5 clk_main = ~clk_main;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic settle();
    @(negedge clk_main);
  endtask

  // Entered with the DUT in FETCH; returns with the DUT in EXECUTE.
  task automatic fetch_decode(input logic [15:0] word, input int wait_cycles,
                              input logic [3:0] prev_dr);
    for (int i = 0; i < wait_cycles; i++) begin
      fetch_ack = 1'b0;
      instr     = 16'h7EEE;
      settle();
      chk("wait_req", fetch_req, 1);
      chk("wait_ps", PS, 0);
      chk("wait_dr", dr, prev_dr);
      tick();
    end
    fetch_ack = 1'b1;
    instr     = word;
    settle();
    chk("fetch_req", fetch_req, 1);
    chk("fetch_ps", PS, 0);
    tick();
    fetch_ack = 1'b0;
    instr     = 16'h7EEE;
    settle();
    chk("dec_ps", PS, 0);
    chk("dec_req", fetch_req, 0);
    chk("dec_rw", rw, 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; fetch_ack = 1'b0; instr = 16'h0000;
    zero_flag = 1'b0; neg_flag = 1'b0;
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_req", fetch_req, 0);
    chk("rst_ps", PS, 0);
    chk("rst_rw", rw, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fields", {sa, sb, dr, fs, offset}, 0);
    tick(); settle();
    chk("idle_hold", fetch_req, 0);

    // ALU op 1: dr=1, sa=2, sb=3
    run = 1'b1;
    tick(); settle();
    chk("idle_to_fetch", fetch_req, 1);
    tick();
    fetch_decode(16'h1123, 0, 4'h0);
    settle();
    chk("alu_ps", PS, 2'b01);
    chk("alu_rw", rw, 1);
    chk("alu_dr", dr, 1);
    chk("alu_fs", fs, 1);
    chk("alu_sa_sb", {sa, sb}, 8'h23);
    tick(); settle();
    chk("alu_after_ps", PS, 0);
    chk("alu_after_rw", rw, 0);
    chk("alu_after_req", fetch_req, 1);
    tick();

    // BRZ taken / not taken
    fetch_decode(16'h8005, 0, 4'h1);
    zero_flag = 1'b1;
    settle();
    chk("brz_taken_ps", PS, 2'b10);
    chk("brz_offset", offset, 5);
    chk("brz_rw", rw, 0);
    tick();
    zero_flag = 1'b0;
    fetch_decode(16'h8005, 0, 4'h0);
    settle();
    chk("brz_not_ps", PS, 2'b01);
    tick();

    // BRN: only neg_flag matters
    fetch_decode(16'h9003, 0, 4'h0);
    zero_flag = 1'b1;
    settle();
    chk("brn_not_ps", PS, 2'b01);
    tick();
    zero_flag = 1'b0;
    fetch_decode(16'h9003, 0, 4'h0);
    neg_flag = 1'b1;
    settle();
    chk("brn_taken_ps", PS, 2'b10);
    tick();
    neg_flag = 1'b0;

    // JMP: PS=11 for exactly one cycle
    fetch_decode(16'hA030, 0, 4'h0);
    settle();
    chk("jmp_sa", sa, 3);
    chk("jmp_ps", PS, 2'b11);
    tick(); settle();
    chk("jmp_after_ps", PS, 0);
    tick();

    // BRA always branches; opcode C is a NOP
    fetch_decode(16'hB007, 0, 4'h0);
    settle();
    chk("bra_ps", PS, 2'b10);
    chk("bra_offset", offset, 7);
    tick();
    fetch_decode(16'hC000, 0, 4'h0);
    settle();
    chk("opc_ps", PS, 2'b01);
    chk("opc_rw", rw, 0);
    tick();

    // Delayed ack, then run drops mid-instruction
    fetch_decode(16'h2456, 4, 4'h0);
    run = 1'b0;
    settle();
    chk("slow_ps", PS, 2'b01);
    chk("slow_rw", rw, 1);
    chk("slow_fields", {dr, sa, sb, fs}, 16'h4562);
    tick(); settle();
    chk("stop_req", fetch_req, 0);
    chk("stop_ps", PS, 0);
    tick(); settle();
    chk("stop_idle", fetch_req, 0);

    // HALT is sticky
    run = 1'b1;
    tick();
    fetch_decode(16'hF000, 0, 4'h4);
    settle();
    chk("halt_exec_ps", PS, 0);
    chk("halt_exec_rw", rw, 0);
    tick();
    fetch_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("halt_flag", halted, 1);
      chk("halt_req", fetch_req, 0);
      chk("halt_ps", PS, 0);
      tick();
    end
    fetch_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_req", fetch_req, 0);
    tick();

    // Reset in DECODE
    settle();
    chk("rd_fetch_req", fetch_req, 1);
    tick();
    fetch_ack = 1'b1;
    instr = 16'h1FFF;
    tick();
    fetch_ack = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rd_req", fetch_req, 0);
    chk("rd_ps", PS, 0);
    chk("rd_rw", rw, 0);
    chk("rd_fields", {sa, sb, dr, fs, offset}, 0);
    tick();

    // Reset in FETCH with a concurrent ack
    settle();
    chk("rf_fetch_req", fetch_req, 1);
    tick();
    reset = 1'b1;
    fetch_ack = 1'b1;
    instr = 16'h2345;
    tick();
    reset = 1'b0;
    fetch_ack = 1'b0;
    run = 1'b0;
    settle();
    chk("rf_req", fetch_req, 0);
    chk("rf_ps", PS, 0);
    tick(); settle();
    chk("rf_idle_req", fetch_req, 0);
    chk("rf_idle_rw", rw, 0);
    chk("rf_idle_dr", dr, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
